mvm_stream_core: RTL and testbench
==================================

# mvm_stream_core

Parametrised, handshaked matrix-vector multiply engine computing y = K·x for an R×C signed matrix K and a C-element signed vector x, one MAC per cycle. It sits between the UART receive deframer and the UART transmit framer inside the MVM UART system. Beyond the fixed-size core it replaces, it adds valid/ready backpressure on both sides, a K-reuse mode (stream only a new x), and optional output saturation.

## Interface
- R, 2: matrix rows / output elements per frame.
- C, 2: matrix columns / x elements.
- W_X, 4: x element width, signed two's complement.
- W_K, 4: K element width, signed two's complement.
- W_Y_OUT, 8: output element width.
- Derived: W_S = max(W_X, W_K); W_ACC = W_X + W_K + clog2(C) (minimum 1 extra bit).

- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- s_data  in  W_S  input element; K uses [W_K-1:0], x uses [W_X-1:0].
- s_valid  in  1  input element valid.
- s_ready  out  1  engine accepts an input element.
- reuse_k  in  1  sampled on the final output handshake of a frame.
- m_data  out  W_Y_OUT  result element y[r].
- m_valid  out  1  result valid.
- m_ready  in  1  downstream accepts result.
- m_last  out  1  high with m_valid for y[R-1].

## Operation
- States: LOAD_K, LOAD_X, COMPUTE, OUT.
- LOAD_K: s_ready=1; accepts R·C elements, row-major (K[0][0], K[0][1], …). After element R·C-1 is accepted → LOAD_X.
- LOAD_X: s_ready=1; accepts C elements x[0..C-1]. After x[C-1] is accepted → COMPUTE with row r=0.
- COMPUTE: s_ready=0. The accumulator clears on entry and adds K[r][c]·x[c] for c=0..C-1, one term per cycle, in full W_ACC precision. After C cycles the result is registered into m_data → OUT.
- OUT: m_valid=1, m_last=(r==R-1). On m_valid&&m_ready:
  - r<R-1: r++ → COMPUTE.
  - r==R-1: → LOAD_X if reuse_k=1 (stored K kept), otherwise → LOAD_K.
- Output width conversion:
  - W_Y_OUT ≥ W_ACC: sign-extend.
  - Otherwise: see Configuration.
- Stored K/x registers have no reset and are overwritten only by accepted elements.

## Timing
- Reset, while rst=1 and on the first cycle after it:
  - State LOAD_K, element index 0, r=0.
  - m_valid=0, m_last=0, m_data=0.
  - s_ready=0 while rst=1; s_ready=1 from the first cycle with rst=0.
- Transfers occur only on valid&&ready at a rising edge.
- s_ready is a pure function of state. m_data, m_valid and m_last are registered.
- Latency:
  - If x[C-1] is accepted at edge t, m_valid rises at edge t+C+1.
  - Each subsequent row starts C+1 cycles after the previous output handshake.
- Backpressure: while m_valid=1 and m_ready=0, m_data and m_last hold stable. No element is dropped or duplicated.
- s_valid gaps in LOAD states stall the indices. No timeout.
- reuse_k is sampled only at the final handshake. Its value at any other time is ignored.
- rst asserted mid-frame (any state) aborts the frame: the next frame starts at LOAD_K and any partial result is discarded.
- Overflow inside W_ACC cannot occur by construction.

## Configuration
- MVM_SAT_EN defined, W_Y_OUT < W_ACC: the accumulator clamps to [-2^(W_Y_OUT-1), 2^(W_Y_OUT-1)-1].
- MVM_SAT_EN undefined: m_data = acc[W_Y_OUT-1:0] (wrap).
- The macro has no effect when W_Y_OUT ≥ W_ACC.

## Test plan
Defaults apply unless noted; W_ACC=9 at defaults.
- Basic frame: K=[[1,2],[3,4]], x=[5,6], m_ready=1 → m_data 17 then 39; m_last only on 39; first m_valid 3 cycles after x[1] is accepted.
- Signed, in range: K=[[-1,2],[3,-4]], x=[7,-8] → -23, 53.
- Saturation: K all -8, x all -8 (true sum 128) → with MVM_SAT_EN, 127 (0x7F) for both rows; without it, 0x80 for both rows.
- Backpressure: m_ready low for 10 cycles during row 0 of the basic frame → m_data=17 held steady, then 39 follows; s_ready=0 throughout.
- K reuse: basic frame with reuse_k=1 at the final handshake, then stream x=[1,1] only → 3, 7. The next frame with reuse_k=0 requires a full K load.
- Reset mid-frame: rst pulsed after 3 K elements → m_valid=0, m_data=0. A subsequent full basic frame yields 17, 39.

Source files
------------

// File: rtl/mvm_stream_core.sv
// mvm_stream_core: handshaked y = K*x engine, one MAC per cycle.
// K is loaded row-major (R*C elements), then x (C elements). Each output row
// is computed in C accumulate cycles plus one cycle that registers the result.
// reuse_k, sampled on the last output handshake, keeps K and streams a new x.
// Optional feature macro: MVM_SAT_EN clamps the result to the W_Y_OUT range
// when W_Y_OUT < W_ACC. Without the macro the result wraps.
module mvm_stream_core #(
  parameter int R       = 2,
  parameter int C       = 2,
  parameter int W_X     = 4,
  parameter int W_K     = 4,
  parameter int W_Y_OUT = 8,
  localparam int W_S    = (W_X > W_K) ? W_X : W_K,
  localparam int W_ACC  = W_X + W_K + ((C > 1) ? $clog2(C) : 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [W_S-1:0]     s_data,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic               reuse_k,
  output logic [W_Y_OUT-1:0] m_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               m_last
);

  localparam int N_K  = R * C;
  localparam int KI_W = (N_K > 1) ? $clog2(N_K) : 1;
  localparam int XI_W = (C > 1) ? $clog2(C) : 1;
  localparam int RI_W = (R > 1) ? $clog2(R) : 1;
  localparam int CI_W = $clog2(C + 1);

  typedef enum logic [1:0] {
    LOAD_K  = 2'd0,
    LOAD_X  = 2'd1,
    COMPUTE = 2'd2,
    OUT     = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [KI_W-1:0] k_idx;
  logic [XI_W-1:0] x_idx;
  logic [RI_W-1:0] r_idx;
  logic [CI_W-1:0] c_cnt;

  logic signed [W_K-1:0] k_mem [N_K];
  logic signed [W_X-1:0] x_mem [C];

  logic signed [W_ACC-1:0] acc;
  logic signed [W_ACC-1:0] k_ext;
  logic signed [W_ACC-1:0] x_ext;
  logic signed [W_ACC-1:0] term;
  logic [KI_W-1:0]         k_addr;
  logic [W_Y_OUT-1:0]      y_conv;

  logic k_last_in;
  logic x_last_in;
  logic c_done;
  logic r_last;
  logic s_hs;
  logic m_hs;

  assign k_last_in = (k_idx == KI_W'(N_K - 1));
  assign x_last_in = (x_idx == XI_W'(C - 1));
  assign c_done    = (c_cnt == CI_W'(C));
  assign r_last    = (r_idx == RI_W'(R - 1));
  assign s_hs      = s_valid && s_ready;
  assign m_hs      = m_valid && m_ready;

  // Input acceptance depends only on the state; held off while in reset.
  assign s_ready = !rst && ((state == LOAD_K) || (state == LOAD_X));

  // State register.
  // NOTE: sequential state is assigned with non-blocking (<=) so every flop
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) state <= LOAD_K;
    else     state <= state_nxt;
  end

  // Next-state decode.
  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      LOAD_K:  if (s_valid && k_last_in) state_nxt = LOAD_X;
      LOAD_X:  if (s_valid && x_last_in) state_nxt = COMPUTE;
      COMPUTE: if (c_done)               state_nxt = OUT;
      OUT: begin
        if (m_ready) begin
          if (!r_last)      state_nxt = COMPUTE;
          else if (reuse_k) state_nxt = LOAD_X;
          else              state_nxt = LOAD_K;
        end
      end
      default: state_nxt = LOAD_K;
    endcase
  end

  // Store accepted K and x elements.
  // NOTE: the element stores have no reset; they are always fully rewritten
  // before use, and leaving reset off lets them map onto plain RAM/regfiles.
  always_ff @(posedge clk) begin
    if (s_hs && (state == LOAD_K)) k_mem[k_idx] <= s_data[W_K-1:0];
    if (s_hs && (state == LOAD_X)) x_mem[x_idx] <= s_data[W_X-1:0];
  end

  // One product term per cycle, sign-extended to full accumulator precision.
  always_comb begin
    k_addr = KI_W'(int'(r_idx) * C + int'(c_cnt));
    k_ext  = W_ACC'(k_mem[k_addr]);
    x_ext  = W_ACC'(x_mem[XI_W'(c_cnt)]);
    term   = k_ext * x_ext;
  end

  // Narrow the accumulator to the output width.
  generate
    if (W_Y_OUT >= W_ACC) begin : g_sext
      always_comb y_conv = W_Y_OUT'(acc);
    end else begin : g_narrow
`ifdef MVM_SAT_EN
      localparam logic signed [W_ACC-1:0] Y_MAX =
        (W_ACC'(1) <<< (W_Y_OUT - 1)) - W_ACC'(1);
      localparam logic signed [W_ACC-1:0] Y_MIN = ~Y_MAX;
      // Clamp to the signed output range.
      always_comb begin
        if (acc > Y_MAX)      y_conv = Y_MAX[W_Y_OUT-1:0];
        else if (acc < Y_MIN) y_conv = Y_MIN[W_Y_OUT-1:0];
        else                  y_conv = acc[W_Y_OUT-1:0];
      end
`else
      // Keep the low bits (two's complement wrap).
      always_comb y_conv = acc[W_Y_OUT-1:0];
`endif
    end
  endgenerate

  // Indices, accumulator and registered output.
  always_ff @(posedge clk) begin
    if (rst) begin
      k_idx   <= '0;
      x_idx   <= '0;
      r_idx   <= '0;
      c_cnt   <= '0;
      acc     <= '0;
      m_data  <= '0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
    end else begin
      case (state)
        LOAD_K: begin
          if (s_valid) k_idx <= k_last_in ? '0 : k_idx + 1'b1;
        end
        LOAD_X: begin
          if (s_valid) begin
            x_idx <= x_last_in ? '0 : x_idx + 1'b1;
            if (x_last_in) begin
              r_idx <= '0;
              c_cnt <= '0;
              acc   <= '0;
            end
          end
        end
        COMPUTE: begin
          if (!c_done) begin
            acc   <= acc + term;
            c_cnt <= c_cnt + 1'b1;
          end else begin
            m_data  <= y_conv;
            m_valid <= 1'b1;
            m_last  <= r_last;
          end
        end
        OUT: begin
          if (m_hs) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            c_cnt   <= '0;
            acc     <= '0;
            r_idx   <= r_last ? '0 : r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mvm_stream_core.sv
// Testbench for mvm_stream_core at default parameters (R=C=2, 4-bit in, 8-bit out).
// Expected outputs are queued as frames are driven and compared on each output
// handshake; table frames plus hand-written latency, backpressure, reuse and
// mid-frame reset sequences.
module tb_mvm_stream_core;

  logic       clk;
  logic       rst;
  logic [3:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic       reuse_k;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       m_last;

  mvm_stream_core dut (
    .clk     (clk),
    .rst     (rst),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .reuse_k (reuse_k),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_last  (m_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0][3:0] k;
    logic [1:0][3:0] x;
    logic [1:0][7:0] y;
    logic            reuse;
    logic            load_k;
  } vec_t;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[7];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic vec_t mk(input int k0, input int k1, input int k2, input int k3,
                              input int x0, input int x1, input int y0, input int y1,
                              input logic reuse, input logic load_k);
    vec_t v;
    v.k[0] = 4'(k0); v.k[1] = 4'(k1); v.k[2] = 4'(k2); v.k[3] = 4'(k3);
    v.x[0] = 4'(x0); v.x[1] = 4'(x1);
    v.y[0] = 8'(y0); v.y[1] = 8'(y1);
    v.reuse  = reuse;
    v.load_k = load_k;
    return v;
  endfunction

  // Output monitor: a handshake seen at the falling edge completes on the next rising edge.
  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_output: got 0x%0h with no result expected", m_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("m_data", {24'd0, m_data}, {24'd0, e.data});
        check("m_last", {31'd0, m_last}, {31'd0, e.last});
      end
    end
  end

  task automatic send(input logic [3:0] d);
    int n;
    n = 0;
    s_data  = d;
    s_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (s_ready) begin
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        return;
      end
      n++;
      if (n > 100) begin
        tests++;
        fails++;
        $display("FAIL send_timeout: s_ready stayed 0 for %0d cycles, expected 1", n);
        s_valid = 1'b0;
        return;
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_empty", sb.size(), 0);
  endtask

  task automatic push_exp(input vec_t v);
    sb.push_back('{data: v.y[0], last: 1'b0});
    sb.push_back('{data: v.y[1], last: 1'b1});
  endtask

  task automatic run_frame(input vec_t v);
    push_exp(v);
    reuse_k = v.reuse;
    if (v.load_k) for (int i = 0; i < 4; i++) send(v.k[i]);
    for (int i = 0; i < 2; i++) send(v.x[i]);
    drain();
    reuse_k = 1'b0;
  endtask

  initial begin
    int n;
    vec_t basic;
    int sat_y;

`ifdef MVM_SAT_EN
    sat_y = 127;
`else
    sat_y = -128;
`endif

    basic   = mk(1, 2, 3, 4, 5, 6, 17, 39, 1'b0, 1'b1);
    vecs[0] = mk(-1, 2, 3, -4, 7, -8, -23, 53, 1'b0, 1'b1);
    vecs[1] = mk(-8, -8, -8, -8, -8, -8, sat_y, sat_y, 1'b0, 1'b1);
    vecs[2] = mk(1, 2, 3, 4, 5, 6, 17, 39, 1'b1, 1'b1);
    vecs[3] = mk(0, 0, 0, 0, 1, 1, 3, 7, 1'b0, 1'b0);
    vecs[4] = mk(-1, 2, 3, -4, 7, -8, -23, 53, 1'b0, 1'b1);
    vecs[5] = mk(7, 7, -8, -8, 7, 7, 98, -112, 1'b0, 1'b1);
    vecs[6] = mk(-8, 7, 0, -1, 7, -8, -112, 8, 1'b0, 1'b1);

    rst     = 1'b1;
    s_data  = '0;
    s_valid = 1'b0;
    reuse_k = 1'b0;
    m_ready = 1'b1;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_m_valid", {31'd0, m_valid}, 0);
    check("rst_m_last", {31'd0, m_last}, 0);
    check("rst_m_data", {24'd0, m_data}, 0);
    check("rst_s_ready", {31'd0, s_ready}, 0);
    rst = 1'b0;
    #1;
    check("post_rst_s_ready", {31'd0, s_ready}, 1);

    // Basic frame with latency check: m_valid rises 3 edges after x[1] is accepted.
    push_exp(basic);
    for (int i = 0; i < 4; i++) send(basic.k[i]);
    send(basic.x[0]);
    send(basic.x[1]);
    check("compute_s_ready", {31'd0, s_ready}, 0);
    check("lat_valid_t0", {31'd0, m_valid}, 0);
    @(posedge clk); #1;
    check("lat_valid_t1", {31'd0, m_valid}, 0);
    @(posedge clk); #1;
    check("lat_valid_t2", {31'd0, m_valid}, 0);
    @(posedge clk); #1;
    check("lat_valid_t3", {31'd0, m_valid}, 1);
    drain();

    // Table-driven frames (signed, saturation/wrap, reuse, x-only, full reload, extremes).
    for (int i = 0; i < 7; i++) run_frame(vecs[i]);

    // Backpressure: hold m_ready low while row 0 is presented.
    m_ready = 1'b0;
    push_exp(basic);
    for (int i = 0; i < 4; i++) send(basic.k[i]);
    send(basic.x[0]);
    send(basic.x[1]);
    n = 0;
    while (!m_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("bp_valid", {31'd0, m_valid}, 1);
    for (int i = 0; i < 10; i++) begin
      check("bp_hold_data", {24'd0, m_data}, 17);
      check("bp_hold_last", {31'd0, m_last}, 0);
      check("bp_s_ready", {31'd0, s_ready}, 0);
      @(posedge clk); #1;
    end
    m_ready = 1'b1;
    drain();

    // Reset mid-frame after three K elements.
    send(4'd1);
    send(4'd2);
    send(4'd3);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_m_valid", {31'd0, m_valid}, 0);
    check("mid_rst_m_data", {24'd0, m_data}, 0);
    check("mid_rst_s_ready", {31'd0, s_ready}, 0);
    rst = 1'b0;
    #1;
    check("mid_rst_release_s_ready", {31'd0, s_ready}, 1);
    run_frame(basic);

    repeat (3) @(posedge clk);
    #1;
    check("idle_m_valid", {31'd0, m_valid}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
